// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer.
// Steps FETCH/DECODE/EXE/MEM/WB for the supported ISA subset and drives the
// datapath enables and muxes. Adds a memory-ready handshake with a wait
// watchdog, an illegal-instruction trap and a retired-instruction counter.
// Outputs are decoded combinationally from the state register and live inputs.
module mc_ctrl_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_MAX      = 15,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             ext_zero,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       data_to_reg,
    output logic [3:0]       state_o,
    output logic             inst_done,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit WD_EN = (MEM_HANDSHAKE != 0) && (WAIT_MAX > 0);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE_R  = 4'd2,
        S_WB_R   = 4'd3,
        S_EXE_I  = 4'd4,
        S_WB_I   = 4'd5,
        S_EXE_MA = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_LW  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt;
    logic [5:0]    opcode, funct;
    logic          rdy, in_mem, timeout, is_nop;
    logic          r_ok, i_ok, i_zext;
    logic [3:0]    r_alu, i_alu;

    assign opcode  = inst[31:26];
    assign funct   = inst[5:0];
    assign is_nop  = (inst == 32'd0);
    // Without the handshake every memory access completes in one cycle.
    assign rdy     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign in_mem  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Fires on the WAIT_MAX-th consecutive stalled cycle; a ready on that cycle wins.
    assign timeout = WD_EN && in_mem && !rdy && (wait_cnt == WAIT_LAST);

    // R-type funct decode: ALU operation and whether the funct is supported.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_XOR:  r_alu = ALU_XOR;
            FN_NOR:  r_alu = ALU_NOR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_SLL:  r_alu = ALU_SLL;
            FN_SRL:  r_alu = ALU_SRL;
            default: r_ok  = 1'b0;
        endcase
    end

    // I-type ALU opcode decode: ALU operation and immediate extension mode.
    always_comb begin
        i_ok   = 1'b1;
        i_alu  = ALU_ADD;
        i_zext = 1'b0;
        case (opcode)
            OP_ADDI: i_alu = ALU_ADD;
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
            OP_XORI: begin i_alu = ALU_XOR; i_zext = 1'b1; end
            OP_LUI:  i_alu = ALU_ADD;
            default: i_ok  = 1'b0;
        endcase
    end

    // Next-state sequencing, including dispatch out of DECODE.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (timeout)  state_nx = S_TRAP;
                else if (rdy) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop)               state_nx = S_FETCH;
                else if (opcode == OP_R) begin
                    if (funct == FN_JR)   state_nx = S_JR;
                    else if (r_ok)        state_nx = S_EXE_R;
                    else                  state_nx = S_TRAP;
                end
                else if (i_ok)            state_nx = S_EXE_I;
                else begin
                    case (opcode)
                        OP_LW, OP_SW:     state_nx = S_EXE_MA;
                        OP_BEQ, OP_BNE:   state_nx = S_BRANCH;
                        OP_J:             state_nx = S_JUMP;
                        OP_JAL:           state_nx = S_JAL;
                        default:          state_nx = S_TRAP;
                    endcase
                end
            end
            S_EXE_R:  state_nx = S_WB_R;
            S_EXE_I:  state_nx = S_WB_I;
            S_EXE_MA: state_nx = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (timeout)  state_nx = S_TRAP;
                else if (rdy) state_nx = S_WB_LW;
            end
            S_MEM_WR: begin
                if (timeout)  state_nx = S_TRAP;
                else if (rdy) state_nx = S_FETCH;
            end
            default:  state_nx = S_FETCH;
        endcase
    end

    // State, wait counter and retired counter; the counter restarts whenever a stall ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_nx;
            if (in_mem && !rdy && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                            wait_cnt <= '0;
            if (inst_done) retired <= retired + 1'b1;
        end
    end

    // Datapath control decode; everything is held low while reset is asserted.
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_AND;
        ext_zero    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        data_to_reg = 2'b00;
        state_o     = 4'd0;
        inst_done   = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            state_o     = state;
            mem_timeout = timeout;
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = rdy;
                    pc_write  = rdy;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    inst_done = is_nop;
                end
                S_EXE_R: begin
                    alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? 2'b10 : 2'b01;
                    alu_ctrl  = r_alu;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                    inst_done = 1'b1;
                end
                S_EXE_I: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_ctrl  = i_alu;
                    ext_zero  = i_zext;
                end
                S_WB_I: begin
                    reg_write   = 1'b1;
                    data_to_reg = (opcode == OP_LUI) ? 2'b10 : 2'b00;
                    inst_done   = 1'b1;
                end
                S_EXE_MA: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    inst_done = rdy;
                end
                S_WB_LW: begin
                    reg_write   = 1'b1;
                    data_to_reg = 2'b01;
                    inst_done   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b01;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                    inst_done = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_src    = 2'b10;
                    inst_done = 1'b1;
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_src    = 2'b11;
                    inst_done = 1'b1;
                end
                S_JAL: begin
                    pc_write    = 1'b1;
                    pc_src      = 2'b10;
                    reg_write   = 1'b1;
                    reg_dst     = 2'b10;
                    data_to_reg = 2'b11;
                    inst_done   = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

endmodule
